// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave endpoint.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

  // Slave controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_slv_state_t;

  // Supported bus mode encoded as {CPOL, CPHA}; only mode 0 is implemented.
  localparam logic [1:0] SPI_MODE0 = 2'b00;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for one asynchronous bus pin with rise/fall pulse outputs.
// Latency: SYNC_STAGES cycles to level; rise/fall pulses are acted on by the consumer one cycle later.
// Backpressure: none; pulses are single-cycle and must be consumed when they occur.
// Ports: clk/rst_n system clock and async active-low reset; din raw pin; level synchronised value;
//        rise/fall one-cycle pulses comparing the synchronised value with the one before it.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Reset to the pin's idle level so that leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI slave, oversampled on clk; deserialises mosi into rx_data and serialises a held tx word on miso.
// Latency: SYNC_STAGES+1 clk from pin edge to action; rx_valid the cycle after the DATA_W-th detected sclk rise.
// Backpressure: none on receive; transmit uses tx_valid/tx_ready into a one-word holding register.
// Ports: clk, rst_n; SPI bus sclk, mosi, ss_n in and miso, miso_oe out;
//        tx_data/tx_valid/tx_ready transmit holding register; rx_data/rx_valid receive; tx_underrun sticky flag.
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun
);

  import spi_pkg::*;

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // Synchronised bus inputs.
  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;
  logic ss_level, ss_rise, ss_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (mosi),
    .level (mosi_level),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  // ss_n idles high, so its synchroniser resets high.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ss_n),
    .level (ss_level),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  spi_slv_state_t    state;
  logic [DATA_W-1:0] tx_hold;
  logic              tx_full;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] load_word;
  logic [CNT_W-1:0]  bit_cnt;
  logic              word_done;
  logic              deselect;
  logic              accept;
  logic              load_now;

  always_comb begin
    // The level term also catches a deselect that coincided with the LOAD cycle.
    deselect  = ss_rise | ss_level;
    accept    = tx_valid & ~tx_full;
    // Shift register is refilled at select and on the falling edge closing each word.
    load_now  = (state == ST_LOAD) ||
                ((state == ST_SHIFT) && !deselect && sclk_fall && word_done);
    load_word = tx_full ? tx_hold : '0;
    // Received word including the bit arriving on this rise.
    rx_next   = {rx_shift, mosi_level};
  end

  assign tx_ready = ~tx_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tx_hold     <= '0;
      tx_full     <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      word_done   <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      // Holding register: an accept only happens while empty, so a same-cycle
      // load takes zeros (underrun) and the new word is still retained.
      if (accept) begin
        tx_hold <= tx_data;
        tx_full <= 1'b1;
      end else if (load_now) begin
        tx_full <= 1'b0;
      end

      if (load_now && !tx_full) begin
        tx_underrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          miso      <= 1'b0;
          miso_oe   <= 1'b0;
          bit_cnt   <= '0;
          word_done <= 1'b0;
          if (ss_fall) begin
            state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          tx_shift  <= load_word;
          miso      <= load_word[DATA_W-1];
          miso_oe   <= 1'b1;
          bit_cnt   <= '0;
          word_done <= 1'b0;
          state     <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (deselect) begin
            // Any partial word is dropped.
            state     <= ST_IDLE;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift <= rx_next[DATA_W-2:0];
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              rx_data   <= rx_next;
              rx_valid  <= 1'b1;
              bit_cnt   <= '0;
              word_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (sclk_fall) begin
            if (word_done) begin
              tx_shift  <= load_word;
              miso      <= load_word[DATA_W-1];
              word_done <= 1'b0;
            end else begin
              tx_shift <= tx_shift << 1;
              miso     <= tx_shift[DATA_W-2];
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave acting as a mode-0 SPI master.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_slave;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       mosi;
  logic       ss_n;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;

  int tests;
  int fails;

  logic [7:0] rx_log[$];

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .mosi        (mosi),
    .ss_n        (ss_n),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every received word, sampled on the opposite clock edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_log.push_back(rx_data);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ss_n     = 1'b1;
    sclk     = 1'b0;
    mosi     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(5);
    rx_log.delete();
  endtask

  // Push one word into the holding register, waiting (bounded) for tx_ready.
  task automatic push_tx(input logic [7:0] d);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 40) begin
      wait_clks(1);
      n++;
    end
    tests++;
    if (tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL push_wait: tx_ready=%b after %0d cycles, required 1", tx_ready, n);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clks(1);
    tx_valid = 1'b0;
  endtask

  // Master side of a mode-0 transfer: mosi set while sclk low, miso sampled at the rise.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_clks(4);
      sclk = 1'b1;
      mi   = {mi[6:0], miso};
      wait_clks(4);
      sclk = 1'b0;
    end
  endtask

  task automatic select();
    ss_n = 1'b0;
    wait_clks(10);
  endtask

  task automatic deselect();
    wait_clks(4);
    ss_n = 1'b1;
    wait_clks(10);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (miso !== 1'b0)        begin fails++; $display("FAIL reset_miso: got %b want 0", miso); end
    tests++; if (miso_oe !== 1'b0)     begin fails++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe); end
    tests++; if (tx_ready !== 1'b1)    begin fails++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    tests++; if (rx_data !== 8'h00)    begin fails++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    tests++; if (rx_valid !== 1'b0)    begin fails++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    tests++; if (tx_underrun !== 1'b0) begin fails++; $display("FAIL reset_tx_underrun: got %b want 0", tx_underrun); end
    // Clock toggling while deselected must be ignored.
    for (int i = 0; i < 8; i++) begin
      mosi = ~mosi;
      wait_clks(4);
      sclk = 1'b1;
      wait_clks(4);
      sclk = 1'b0;
      tests++;
      if (miso_oe !== 1'b0) begin fails++; $display("FAIL idle_miso_oe bit %0d: got %b want 0", i, miso_oe); end
    end
    wait_clks(10);
    tests++; if (rx_log.size() != 0) begin fails++; $display("FAIL idle_rx_valid: got %0d pulses want 0", rx_log.size()); end
  endtask

  task automatic test_single();
    logic [7:0] got;
    do_reset();
    push_tx(8'h3C);
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL single_tx_full: tx_ready=%b want 0", tx_ready); end
    select();
    tests++; if (miso_oe !== 1'b1) begin fails++; $display("FAIL single_miso_oe: got %b want 1", miso_oe); end
    spi_bits(8'hAA, 8, got);
    deselect();
    tests++; if (rx_log.size() != 1) begin fails++; $display("FAIL single_rx_count: got %0d want 1", rx_log.size()); end
    tests++; if (rx_data !== 8'hAA) begin fails++; $display("FAIL single_rx_data: got %h want aa", rx_data); end
    tests++; if (got !== 8'h3C) begin fails++; $display("FAIL single_miso_word: got %h want 3c", got); end
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL single_tx_ready: got %b want 1", tx_ready); end
    tests++; if (miso_oe !== 1'b0) begin fails++; $display("FAIL single_oe_off: got %b want 0", miso_oe); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g0, g1;
    do_reset();
    push_tx(8'h12);
    select();
    push_tx(8'h34);
    spi_bits(8'h55, 8, g0);
    spi_bits(8'hA5, 8, g1);
    deselect();
    tests++; if (rx_log.size() != 2) begin fails++; $display("FAIL b2b_rx_count: got %0d want 2", rx_log.size()); end
    if (rx_log.size() == 2) begin
      tests++; if (rx_log[0] !== 8'h55) begin fails++; $display("FAIL b2b_rx0: got %h want 55", rx_log[0]); end
      tests++; if (rx_log[1] !== 8'hA5) begin fails++; $display("FAIL b2b_rx1: got %h want a5", rx_log[1]); end
    end
    tests++; if (g0 !== 8'h12) begin fails++; $display("FAIL b2b_miso0: got %h want 12", g0); end
    tests++; if (g1 !== 8'h34) begin fails++; $display("FAIL b2b_miso1: got %h want 34", g1); end
  endtask

  task automatic test_underrun();
    logic [7:0] got;
    do_reset();
    tests++; if (tx_underrun !== 1'b0) begin fails++; $display("FAIL under_pre: got %b want 0", tx_underrun); end
    select();
    spi_bits(8'hFF, 8, got);
    deselect();
    tests++; if (rx_data !== 8'hFF) begin fails++; $display("FAIL under_rx_data: got %h want ff", rx_data); end
    tests++; if (got !== 8'h00) begin fails++; $display("FAIL under_miso_word: got %h want 00", got); end
    tests++; if (tx_underrun !== 1'b1) begin fails++; $display("FAIL under_flag: got %b want 1", tx_underrun); end
    // A later well-fed transfer must not clear the sticky flag.
    push_tx(8'h81);
    select();
    spi_bits(8'h00, 8, got);
    deselect();
    tests++; if (got !== 8'h81) begin fails++; $display("FAIL under_next_miso: got %h want 81", got); end
    tests++; if (tx_underrun !== 1'b1) begin fails++; $display("FAIL under_sticky: got %b want 1", tx_underrun); end
  endtask

  task automatic test_partial();
    logic [7:0] got;
    do_reset();
    select();
    spi_bits(8'hAA, 5, got);
    deselect();
    tests++; if (rx_log.size() != 0) begin fails++; $display("FAIL partial_rx_count: got %0d want 0", rx_log.size()); end
    select();
    spi_bits(8'h55, 8, got);
    deselect();
    tests++; if (rx_log.size() != 1) begin fails++; $display("FAIL partial_next_count: got %0d want 1", rx_log.size()); end
    tests++; if (rx_data !== 8'h55) begin fails++; $display("FAIL partial_next_data: got %h want 55", rx_data); end
  endtask

  // Runs straight after test_partial so rx_data, tx_underrun are non-reset before the pulse.
  task automatic test_reset_mid();
    logic [7:0] got;
    select();
    push_tx(8'h3C);
    spi_bits(8'hC3, 3, got);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (miso !== 1'b0)        begin fails++; $display("FAIL rstmid_miso: got %b want 0", miso); end
    tests++; if (miso_oe !== 1'b0)     begin fails++; $display("FAIL rstmid_miso_oe: got %b want 0", miso_oe); end
    tests++; if (tx_ready !== 1'b1)    begin fails++; $display("FAIL rstmid_tx_ready: got %b want 1", tx_ready); end
    tests++; if (rx_data !== 8'h00)    begin fails++; $display("FAIL rstmid_rx_data: got %h want 00", rx_data); end
    tests++; if (rx_valid !== 1'b0)    begin fails++; $display("FAIL rstmid_rx_valid: got %b want 0", rx_valid); end
    tests++; if (tx_underrun !== 1'b0) begin fails++; $display("FAIL rstmid_tx_underrun: got %b want 0", tx_underrun); end
    ss_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(5);
    rx_log.delete();
    select();
    spi_bits(8'hC3, 8, got);
    deselect();
    tests++; if (rx_log.size() != 1) begin fails++; $display("FAIL rstmid_next_count: got %0d want 1", rx_log.size()); end
    tests++; if (rx_data !== 8'hC3) begin fails++; $display("FAIL rstmid_next_data: got %h want c3", rx_data); end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    ss_n     = 1'b1;
    sclk     = 1'b0;
    mosi     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_partial();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
